// File: rtl/read_pointer_empty_if.sv
// Read-side FIFO pointer bundle: pop request, synchronized write pointer,
// and the registered flags/pointers produced by the read-pointer block.
interface read_pointer_empty_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  read_enable;
    logic [ADDR_WIDTH:0]   sync_write_pointer;
    logic                  underflow_clear;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH-1:0] read_address;
    logic [ADDR_WIDTH:0]   read_pointer;
    logic [ADDR_WIDTH:0]   read_count;
    logic                  underflow;

    modport master (
        output read_enable,
        output sync_write_pointer,
        output underflow_clear,
        input  empty,
        input  almost_empty,
        input  read_address,
        input  read_pointer,
        input  read_count,
        input  underflow
    );

    modport slave (
        input  read_enable,
        input  sync_write_pointer,
        input  underflow_clear,
        output empty,
        output almost_empty,
        output read_address,
        output read_pointer,
        output read_count,
        output underflow
    );
endinterface

// File: rtl/read_pointer_empty.sv
// Async-FIFO read pointer: binary/Gray pointer pair, registered empty,
// almost-empty and occupancy flags, and a sticky underflow flag.
module read_pointer_empty #(
    parameter int ADDR_WIDTH   = 7,
    parameter int AE_THRESHOLD = 4
) (
    input logic                 clock_read,
    input logic                 read_reset_n,
    read_pointer_empty_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESHOLD);

    logic [PW-1:0] read_binary;
    logic [PW-1:0] read_binary_next;
    logic [PW-1:0] read_gray_next;
    logic [PW-1:0] write_binary;
    logic [PW-1:0] occupancy_next;
    logic          pop;
    logic          underflow_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        write_binary = '0;
        for (int i = 0; i < PW; i++) begin
            write_binary[i] = ^(bus.sync_write_pointer >> i);
        end
    end

    assign pop              = bus.read_enable & ~bus.empty;
    assign read_binary_next = read_binary + PW'(pop);
    assign read_gray_next   = (read_binary_next >> 1) ^ read_binary_next;
    assign occupancy_next   = write_binary - read_binary_next;
    assign underflow_next   = (bus.read_enable & bus.empty)
                            | (bus.underflow & ~bus.underflow_clear);
    assign bus.read_address = read_binary[ADDR_WIDTH-1:0];

    always_ff @(posedge clock_read or negedge read_reset_n) begin
        if (!read_reset_n) begin
            read_binary      <= '0;
            bus.read_pointer <= '0;
            bus.empty        <= 1'b1;
            bus.almost_empty <= 1'b1;
            bus.read_count   <= '0;
            bus.underflow    <= 1'b0;
        end else begin
            read_binary      <= read_binary_next;
            bus.read_pointer <= read_gray_next;
            bus.empty        <= (read_gray_next == bus.sync_write_pointer);
            bus.almost_empty <= (occupancy_next <= AE_LIMIT);
            bus.read_count   <= occupancy_next;
            bus.underflow    <= underflow_next;
        end
    end
endmodule

// File: tb/tb_read_pointer_empty.sv
// Randomized and directed bench for read_pointer_empty against a
// count-based FIFO occupancy model.
module tb_read_pointer_empty;
    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    // Model: total words written and popped since reset, plus flags
    int   wr_total;
    int   rd_total;
    logic m_empty;
    logic m_uf;

    read_pointer_empty_if #(.ADDR_WIDTH(7)) bus ();

    read_pointer_empty #(
        .ADDR_WIDTH(7),
        .AE_THRESHOLD(4)
    ) dut (
        .clock_read(clk),
        .read_reset_n(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_gray(input int b);
        logic [7:0] v;
        v = 8'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp,
                     $time);
        end
    endtask

    task automatic chk_all(input string tag);
        int occ;
        occ = wr_total - rd_total;
        chk({tag, ".ptr"}, 32'(bus.read_pointer), 32'(to_gray(rd_total)));
        chk({tag, ".addr"}, 32'(bus.read_address), 32'(rd_total % 128));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(m_empty));
        chk({tag, ".ae"}, 32'(bus.almost_empty), 32'(occ <= 4));
        chk({tag, ".count"}, 32'(bus.read_count), 32'(occ));
        chk({tag, ".uf"}, 32'(bus.underflow), 32'(m_uf));
    endtask

    task automatic model_reset();
        wr_total = 0;
        rd_total = 0;
        m_empty  = 1'b1;
        m_uf     = 1'b0;
    endtask

    // One clock: drive at negedge, update model at posedge, check after it
    task automatic step(input logic re, input int wr, input logic clr,
                        input string tag);
        logic was_empty;
        @(negedge clk);
        bus.read_enable        = re;
        bus.sync_write_pointer = to_gray(wr);
        bus.underflow_clear    = clr;
        @(posedge clk);
        was_empty = m_empty;
        if (re && !was_empty) rd_total++;
        wr_total = wr;
        m_empty  = (wr_total == rd_total);
        m_uf     = (re && was_empty) || (m_uf && !clr);
        #1;
        chk_all(tag);
    endtask

    initial begin
        int wr;
        rst_n                  = 1'b0;
        bus.read_enable        = 1'b0;
        bus.sync_write_pointer = 8'h00;
        bus.underflow_clear    = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 0, "idle");
        step(0, 1, 0, "wr1");
        step(0, 5, 0, "wr5");
        for (int i = 0; i < 5; i++) step(1, 5, 0, "pop5");
        chk("drained.ptr", 32'(bus.read_pointer), 32'h07);

        step(1, 5, 0, "uf_set");
        step(0, 5, 1, "uf_clr");
        step(1, 5, 1, "uf_both");
        step(0, 5, 1, "uf_clr2");

        // Keep the writer three ahead while popping a full pointer lap
        step(0, rd_total + 3, 0, "lap_fill");
        for (int i = 0; i < 256; i++) step(1, rd_total + 4, 0, "lap");

        step(0, rd_total + 10, 0, "fill10");
        chk("fill10.count", 32'(bus.read_count), 32'd10);
        @(negedge clk);
        #2;
        rst_n                  = 1'b0;
        bus.sync_write_pointer = 8'h00;
        bus.read_enable        = 1'b0;
        model_reset();
        #1;
        chk_all("midreset");
        #1;
        rst_n = 1'b1;

        wr = 0;
        for (int i = 0; i < 600; i++) begin
            int inc;
            logic re;
            inc = $urandom_range(0, 2);
            if (wr + inc - rd_total > 128) inc = 0;
            if ($urandom_range(0, 15) == 0) inc = 128 - (wr - rd_total);
            re = ($urandom_range(0, 3) != 0);
            wr = wr + inc;
            step(re, wr, ($urandom_range(0, 7) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/read_pointer_empty.md
READ_POINTER_EMPTY -- requirements
Module: read_pointer_empty

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: memory address width; FIFO depth is 2^ADDR_WIDTH = 128; pointers are ADDR_WIDTH+1 = 8 bits.
REQ-002 Parameter AE_THRESHOLD, default 4: almost_empty asserts when occupancy is at or below this value.
REQ-003 clock_read  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 read_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 read_enable  input  1  consumer requests a pop this cycle.
REQ-006 sync_write_pointer  input  8  Gray-coded write pointer, already double-synchronized into the read domain outside this block.
REQ-007 underflow_clear  input  1  clears the sticky underflow flag.
REQ-008 empty  output  1  registered FIFO-empty flag.
REQ-009 almost_empty  output  1  registered flag: occupancy <= AE_THRESHOLD.
REQ-010 read_address  output  7  memory read address, equal to read_binary[6:0].
REQ-011 read_pointer  output  8  registered Gray-coded read pointer, sent to the write-domain synchronizer.
REQ-012 read_count  output  8  registered read-side occupancy, 0..128.
REQ-013 underflow  output  1  sticky flag: a pop was attempted while empty.

Function
REQ-014 Internal 8-bit binary register read_binary and Gray register read_pointer SHALL both be held and update together each clock.
REQ-015 read_binary_next SHALL equal read_binary + (read_enable & ~empty), modulo 256.
REQ-016 read_gray_next SHALL equal (read_binary_next >> 1) XOR read_binary_next.
REQ-017 A pop while empty is 1 SHALL leave read_binary, read_pointer, and read_address unchanged.
REQ-018 Pointers SHALL wrap naturally: binary 255 -> 0; Gray 8'h80 -> 8'h00; no other special handling.
REQ-019 empty SHALL register (read_gray_next == sync_write_pointer) every clock.
REQ-020 write_binary SHALL be the combinational Gray-to-binary conversion of sync_write_pointer: bit 7 = g[7]; bit i = bit i+1 XOR g[i].
REQ-021 read_count SHALL register (write_binary - read_binary_next) modulo 256.
REQ-022 almost_empty SHALL register (write_binary - read_binary_next) <= AE_THRESHOLD.
REQ-023 Flag latency: a change on sync_write_pointer SHALL be reflected on empty, read_count, and almost_empty on the next rising clock edge.
REQ-024 A pop SHALL be reflected on the same next rising clock edge, using read_binary_next.
REQ-025 If a pop and a sync_write_pointer change occur in the same cycle, both SHALL be applied in the same registered update.
REQ-026 underflow SHALL set on a clock where read_enable=1 and empty=1.
REQ-027 underflow SHALL clear on a clock where underflow_clear=1 and no new underflow occurs.
REQ-028 If underflow set and clear coincide, set SHALL win.
REQ-029 read_address SHALL be combinational from read_binary; it is stable for the whole cycle following the pop edge.

Reset
REQ-030 read_reset_n=0 SHALL immediately, without a clock, force:
- read_binary=0, read_pointer=8'h00;
- empty=1, almost_empty=1;
- read_count=0, underflow=0.
REQ-031 Reset deassertion SHALL take effect on the first rising clock edge after read_reset_n returns high.
REQ-032 Reset asserted mid-operation SHALL discard all state; no pending pop completes.

Verification
REQ-033 Reset held low -> empty=1, almost_empty=1, read_pointer=8'h00, read_address=0, read_count=0, underflow=0.
REQ-034 sync_write_pointer 8'h00 -> 8'h01, read_enable=0 -> after one edge: empty=0, read_count=1, almost_empty=1.
REQ-035 sync_write_pointer=8'h07 (binary 5), read_enable=1 for 5 clocks -> read_address steps 0,1,2,3,4, then 5. After the 5th edge: read_pointer=8'h07, empty=1, read_count=0.
REQ-036 Underflow handling:
- read_enable=1 while empty -> pointer unchanged, underflow=1 next edge;
- underflow_clear=1 alone -> underflow=0;
- clear and new underflow together -> underflow stays 1.
REQ-037 Wrap: keep write pointer 3 ahead, pop 256 times -> read_pointer passes 8'h80 (binary 255) to 8'h00, read_address 127 -> 0, empty stays 0, read_count stays 3.
REQ-038 read_count=10, then read_reset_n pulsed low between clock edges -> all outputs at reset values before the next edge.
